// File: rtl/bus_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_write_arbiter                                               |
// | Purpose  : Round-robin arbiter and driver of the shared PE data bus.       |
// |            Grants one requesting PE per cycle, strobes the destination     |
// |            one cycle later and drives the word on the bus one cycle after. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bus_write_arbiter #(
  parameter int NUM_PE       = 8,
  parameter int BUS_ADDR_LEN = 3,
  parameter int DATA_LEN     = 16,
  parameter int HOLDOFF      = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           stall,
  input  logic [NUM_PE-1:0]              valid_to_bus,
  input  logic [NUM_PE*DATA_LEN-1:0]     data_to_bus,
  input  logic [NUM_PE*BUS_ADDR_LEN-1:0] addr_to_bus,
  input  logic [NUM_PE*NUM_PE-1:0]       rd_buffer_full,
  output logic [NUM_PE-1:0]              wr_to_bus,
  output logic [NUM_PE-1:0]              rd_from_bus,
  output logic [DATA_LEN-1:0]            bus_data,
  output logic [BUS_ADDR_LEN-1:0]        bus_addr,
  output logic                           bus_valid,
  output logic                           drop_err
);

  localparam int PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  logic [PTR_W-1:0]        ptr;
  logic [HOLD_W-1:0]       holdoff [NUM_PE];
  logic [NUM_PE-1:0]       eligible;
  logic                    grant_any;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;
  logic [BUS_ADDR_LEN-1:0] grant_dest;
  logic [DATA_LEN-1:0]     grant_data;

  // Stage 1: granted word waiting to be placed on the bus
  logic                    s1_valid;
  logic [BUS_ADDR_LEN-1:0] s1_src;
  logic [DATA_LEN-1:0]     s1_data;

  for (genvar s = 0; s < NUM_PE; s++) begin : g_elig
    logic [BUS_ADDR_LEN-1:0] dest;
    logic                    blocked;
    assign dest = addr_to_bus[s*BUS_ADDR_LEN +: BUS_ADDR_LEN];

    // A destination outside the PE range has no buffer, so it never blocks
    always_comb begin
      blocked = 1'b0;
      for (int d = 0; d < NUM_PE; d++) begin
        if (dest == BUS_ADDR_LEN'(d)) blocked = rd_buffer_full[d*NUM_PE + s];
      end
    end

    assign eligible[s] = valid_to_bus[s] & (holdoff[s] == '0) & ~stall & ~blocked;
  end

  // Round-robin search starting at ptr; the first eligible PE wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_PE);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign wr_to_bus  = grant_any ? (NUM_PE'(1) << grant_idx) : '0;
  assign grant_dest = addr_to_bus[grant_idx*BUS_ADDR_LEN +: BUS_ADDR_LEN];
  assign grant_data = data_to_bus[grant_idx*DATA_LEN +: DATA_LEN];

  // Pointer advance past the winner and per-PE holdoff countdown
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
      for (int i = 0; i < NUM_PE; i++) holdoff[i] <= '0;
    end else begin
      if (grant_any) begin
        ptr <= (grant_idx == PTR_W'(NUM_PE - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int i = 0; i < NUM_PE; i++) begin
        if (grant_any && (grant_idx == PTR_W'(i))) holdoff[i] <= HOLD_W'(HOLDOFF);
        else if (holdoff[i] != '0)                 holdoff[i] <= holdoff[i] - 1'b1;
      end
    end
  end

  // Grant cycle: capture the word and raise the destination strobe (or the drop flag)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_src      <= '0;
      s1_data     <= '0;
      rd_from_bus <= '0;
      drop_err    <= 1'b0;
    end else begin
      s1_valid    <= grant_any;
      rd_from_bus <= '0;
      drop_err    <= 1'b0;
      if (grant_any) begin
        s1_src  <= BUS_ADDR_LEN'(grant_idx);
        s1_data <= grant_data;
        if (int'(grant_dest) < NUM_PE) rd_from_bus <= NUM_PE'(1) << grant_dest;
        else                           drop_err    <= 1'b1;
      end
    end
  end

  // Strobe cycle: put the word on the bus; data/addr hold while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_valid <= 1'b0;
      bus_data  <= '0;
      bus_addr  <= '0;
    end else begin
      bus_valid <= s1_valid;
      if (s1_valid) begin
        bus_data <= s1_data;
        bus_addr <= s1_src;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bus_write_arbiter                                            |
// | Purpose  : Self-checking bench for bus_write_arbiter (8-PE and 6-PE DUTs). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bus_write_arbiter;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int HO = 3;
  localparam int N6 = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              stall;
  logic [N-1:0]      valid;
  logic [N*DW-1:0]   data;
  logic [N*AW-1:0]   addr;
  logic [N*N-1:0]    full;
  logic [N-1:0]      wr, rd;
  logic [DW-1:0]     bdata;
  logic [AW-1:0]     baddr;
  logic              bvalid, derr;

  logic              stall6;
  logic [N6-1:0]     valid6;
  logic [N6*DW-1:0]  data6;
  logic [N6*AW-1:0]  addr6;
  logic [N6*N6-1:0]  full6;
  logic [N6-1:0]     wr6, rd6;
  logic [DW-1:0]     bdata6;
  logic [AW-1:0]     baddr6;
  logic              bvalid6, derr6;

  int checks   = 0;
  int failures = 0;

  bus_write_arbiter #(.NUM_PE(N), .BUS_ADDR_LEN(AW), .DATA_LEN(DW), .HOLDOFF(HO)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .valid_to_bus(valid), .data_to_bus(data),
    .addr_to_bus(addr), .rd_buffer_full(full), .wr_to_bus(wr), .rd_from_bus(rd),
    .bus_data(bdata), .bus_addr(baddr), .bus_valid(bvalid), .drop_err(derr));

  bus_write_arbiter #(.NUM_PE(N6), .BUS_ADDR_LEN(AW), .DATA_LEN(DW), .HOLDOFF(HO)) dut6 (
    .clk(clk), .rstn(rstn), .stall(stall6), .valid_to_bus(valid6), .data_to_bus(data6),
    .addr_to_bus(addr6), .rd_buffer_full(full6), .wr_to_bus(wr6), .rd_from_bus(rd6),
    .bus_data(bdata6), .bus_addr(baddr6), .bus_valid(bvalid6), .drop_err(derr6));

  task automatic apply_reset();
    rstn = 1'b0;
    stall = 1'b0; valid = '0; data = '0; addr = '0; full = '0;
    stall6 = 1'b0; valid6 = '0; data6 = '0; addr6 = '0; full6 = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_pe(input int p, input bit v, input int d, input int w);
    valid[p]          = v;
    addr[p*AW +: AW]  = AW'(d);
    data[p*DW +: DW]  = DW'(w);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (wr !== '0)     begin failures++; $display("FAIL reset_wr got=%h exp=00", wr); end
    checks++; if (rd !== '0)     begin failures++; $display("FAIL reset_rd got=%h exp=00", rd); end
    checks++; if (bvalid !== 0)  begin failures++; $display("FAIL reset_bus_valid got=%b exp=0", bvalid); end
    checks++; if (bdata !== '0)  begin failures++; $display("FAIL reset_bus_data got=%h exp=0000", bdata); end
    checks++; if (baddr !== '0)  begin failures++; $display("FAIL reset_bus_addr got=%h exp=0", baddr); end
    checks++; if (derr !== 0)    begin failures++; $display("FAIL reset_drop_err got=%b exp=0", derr); end
  endtask

  task automatic test_single_transfer();
    apply_reset();
    set_pe(2, 1, 5, 16'hBEEF);
    #1;
    checks++; if (wr !== 8'h04) begin failures++; $display("FAIL single_grant got=%h exp=04", wr); end
    @(negedge clk); valid = '0; #1;
    checks++; if (rd !== 8'h20) begin failures++; $display("FAIL single_strobe got=%h exp=20", rd); end
    checks++; if (bvalid !== 0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", bvalid); end
    @(negedge clk); #1;
    checks++; if (bvalid !== 1 || bdata !== 16'hBEEF || baddr !== 3'd2)
      begin failures++; $display("FAIL single_bus got v=%b d=%h a=%0d exp v=1 d=beef a=2", bvalid, bdata, baddr); end
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL single_strobe_clear got=%h exp=00", rd); end
    @(negedge clk); #1;
    checks++; if (bvalid !== 0 || bdata !== 16'hBEEF || baddr !== 3'd2)
      begin failures++; $display("FAIL single_hold got v=%b d=%h a=%0d exp v=0 d=beef a=2", bvalid, bdata, baddr); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    apply_reset();
    for (int p = 0; p < N; p++) set_pe(p, 1, (p + 3) % N, 16'h1000 + p);
    for (int c = 0; c < 16; c++) begin
      #1;
      exp = N'(1) << (c % N);
      checks++; if (wr !== exp) begin failures++; $display("FAIL rr_grant cyc=%0d got=%h exp=%h", c, wr, exp); end
      if (c >= 1) begin
        exp = N'(1) << ((c - 1 + 3) % N);
        checks++; if (rd !== exp) begin failures++; $display("FAIL rr_strobe cyc=%0d got=%h exp=%h", c, rd, exp); end
      end
      if (c >= 2) begin
        checks++; if (bvalid !== 1 || baddr !== AW'((c - 2) % N) || bdata !== DW'(16'h1000 + (c - 2) % N))
          begin failures++; $display("FAIL rr_bus cyc=%0d got v=%b a=%0d d=%h", c, bvalid, baddr, bdata); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_block();
    apply_reset();
    set_pe(1, 1, 3, 16'h0111);
    set_pe(4, 1, 0, 16'h0444);
    full[3*N + 1] = 1'b1;
    #1;
    checks++; if (wr !== 8'h10) begin failures++; $display("FAIL full_other_granted got=%h exp=10", wr); end
    @(negedge clk); valid[4] = 1'b0; #1;
    checks++; if (wr !== 8'h00) begin failures++; $display("FAIL full_blocked got=%h exp=00", wr); end
    @(negedge clk); full = '0; #1;
    checks++; if (wr !== 8'h02) begin failures++; $display("FAIL full_released got=%h exp=02", wr); end
    @(negedge clk); valid = '0;
  endtask

  task automatic test_holdoff_stall();
    logic [N-1:0] exp;
    apply_reset();
    set_pe(0, 1, 1, 16'h00A0);
    for (int t = 0; t < 10; t++) begin
      #1;
      exp = (t % (HO + 1) == 0) ? 8'h01 : 8'h00;
      checks++; if (wr !== exp) begin failures++; $display("FAIL holdoff t=%0d got=%h exp=%h", t, wr, exp); end
      @(negedge clk);
    end
    apply_reset();
    set_pe(0, 1, 1, 16'h00A7);
    for (int t = 0; t < 10; t++) begin
      stall = (t >= 2 && t <= 6);
      #1;
      exp = (t == 0 || t == 7) ? 8'h01 : 8'h00;
      checks++; if (wr !== exp) begin failures++; $display("FAIL stall t=%0d got=%h exp=%h", t, wr, exp); end
      if (t == 9) begin
        checks++; if (bvalid !== 1 || bdata !== 16'h00A7)
          begin failures++; $display("FAIL stall_word got v=%b d=%h exp v=1 d=00a7", bvalid, bdata); end
      end
      @(negedge clk);
    end
    valid = '0; stall = 1'b0;
  endtask

  task automatic test_drop();
    apply_reset();
    valid6[5] = 1'b1; addr6[5*AW +: AW] = 3'd7; data6[5*DW +: DW] = 16'h0DEF;
    #1;
    checks++; if (wr6 !== 6'h20) begin failures++; $display("FAIL drop_grant got=%h exp=20", wr6); end
    @(negedge clk); valid6 = '0; #1;
    checks++; if (derr6 !== 1 || rd6 !== '0)
      begin failures++; $display("FAIL drop_pulse got err=%b rd=%h exp err=1 rd=00", derr6, rd6); end
    @(negedge clk); #1;
    checks++; if (bvalid6 !== 1 || baddr6 !== 3'd5 || bdata6 !== 16'h0DEF || derr6 !== 0)
      begin failures++; $display("FAIL drop_bus got v=%b a=%0d d=%h err=%b", bvalid6, baddr6, bdata6, derr6); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_pe(3, 1, 6, 16'h3333);
    #1;
    checks++; if (wr !== 8'h08) begin failures++; $display("FAIL rstmid_grant got=%h exp=08", wr); end
    @(posedge clk); #1 rstn = 1'b0; valid = '0;
    #1;
    checks++; if (rd !== '0 || bvalid !== 0 || derr !== 0)
      begin failures++; $display("FAIL rstmid_clear got rd=%h v=%b err=%b exp 0", rd, bvalid, derr); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    set_pe(0, 1, 1, 16'h0000);
    set_pe(5, 1, 1, 16'h0005);
    #1;
    checks++; if (wr !== 8'h01) begin failures++; $display("FAIL rstmid_ptr got=%h exp=01", wr); end
    @(negedge clk); valid = '0; #1;
    checks++; if (bvalid !== 0) begin failures++; $display("FAIL rstmid_ghost got v=%b exp=0", bvalid); end
    @(negedge clk); #1;
    checks++; if (bvalid !== 1 || baddr !== 3'd0)
      begin failures++; $display("FAIL rstmid_resume got v=%b a=%0d exp v=1 a=0", bvalid, baddr); end
  endtask

  task automatic test_random();
    int m_ptr;
    int m_hold [N];
    int g, s, d;
    bit g1v, g2v;
    int g1s, g1d, g1w, g2s, g2w;
    int held_w, held_s;
    logic [N-1:0]  e_wr, e_rd;
    logic [DW-1:0] e_bd;
    logic [AW-1:0] e_ba;
    apply_reset();
    m_ptr = 0; g1v = 0; g2v = 0; g1s = 0; g1d = 0; g1w = 0; g2s = 0; g2w = 0;
    held_w = 0; held_s = 0;
    for (int i = 0; i < N; i++) m_hold[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      valid = N'($urandom);
      for (int p = 0; p < N; p++) begin
        addr[p*AW +: AW] = AW'($urandom_range(0, N - 1));
        data[p*DW +: DW] = DW'($urandom_range(0, 65535));
      end
      full  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      stall = ($urandom_range(0, 5) == 0);
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        s = (m_ptr + k) % N;
        d = int'(addr[s*AW +: AW]);
        if (g < 0 && valid[s] && m_hold[s] == 0 && !stall && (d >= N || !full[d*N + s])) g = s;
      end
      e_wr = (g < 0) ? '0 : (N'(1) << g);
      e_rd = (g1v && g1d < N) ? (N'(1) << g1d) : '0;
      e_bd = g2v ? DW'(g2w) : DW'(held_w);
      e_ba = g2v ? AW'(g2s) : AW'(held_s);
      checks++; if (wr !== e_wr) begin failures++; $display("FAIL rand_grant cyc=%0d got=%h exp=%h", cyc, wr, e_wr); end
      checks++; if (rd !== e_rd) begin failures++; $display("FAIL rand_strobe cyc=%0d got=%h exp=%h", cyc, rd, e_rd); end
      checks++; if (bvalid !== g2v || bdata !== e_bd || baddr !== e_ba || derr !== (g1v && g1d >= N))
        begin failures++; $display("FAIL rand_bus cyc=%0d got v=%b d=%h a=%0d err=%b exp v=%b d=%h a=%0d",
                                   cyc, bvalid, bdata, baddr, derr, g2v, e_bd, e_ba); end
      @(posedge clk);
      for (int p = 0; p < N; p++) begin
        if (p == g) m_hold[p] = HO;
        else if (m_hold[p] > 0) m_hold[p] = m_hold[p] - 1;
      end
      if (g >= 0) m_ptr = (g + 1) % N;
      if (g2v) begin held_w = g2w; held_s = g2s; end
      g2v = g1v; g2s = g1s; g2w = g1w;
      g1v = (g >= 0);
      if (g >= 0) begin
        g1s = g;
        g1d = int'(addr[g*AW +: AW]);
        g1w = int'(data[g*DW +: DW]);
      end
      @(negedge clk);
    end
    valid = '0; stall = 1'b0; full = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_transfer();
    test_round_robin();
    test_full_block();
    test_holdoff_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
